// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants for the hazard/stall controller.
// Optional feature macro: HAZARD_PERF_EN (stall performance counters).
package hazard_stall_ctrl_pkg;

    // Tuse code meaning "this source register is not read".
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Default mult/div busy lengths and countdown width.
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    // Architectural zero register; never a hazard source.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when a source read at tuse would arrive before the producer's tnew.
    function automatic logic src_hit(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic [4:0] dst, input logic [1:0] tnew);
        return (src != REG_ZERO) && (src == dst) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of ID/EX/MEM hazard inputs and stall outputs.
// Optional feature macro: HAZARD_PERF_EN adds the stall counter outputs.
// Signals are level-based: every input is sampled each cycle, every output
// is a same-cycle response; there is no valid/ready handshake.
interface hazard_stall_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [1:0] id_tuse_rs;
    logic [1:0] id_tuse_rt;
    logic       id_is_md;
    logic [4:0] ex_dst;
    logic [1:0] ex_tnew;
    logic [4:0] mem_dst;
    logic [1:0] mem_tnew;
    logic       ex_md_start;
    logic       ex_md_is_div;
    logic       stall;
    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_flush;
    logic       md_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] md_stall_cycles;
`endif

    modport master (
        output id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_is_md,
        output ex_dst, ex_tnew, mem_dst, mem_tnew, ex_md_start, ex_md_is_div,
`ifdef HAZARD_PERF_EN
        input  stall_cycles, md_stall_cycles,
`endif
        input  stall, pc_en, if_id_en, id_ex_flush, md_busy
    );

    modport slave (
        input  id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_is_md,
        input  ex_dst, ex_tnew, mem_dst, mem_tnew, ex_md_start, ex_md_is_div,
`ifdef HAZARD_PERF_EN
        output stall_cycles, md_stall_cycles,
`endif
        output stall, pc_en, if_id_en, id_ex_flush, md_busy
    );
endinterface

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Mult/div busy countdown: a start loads N, then counts down to zero.
// busy is high for exactly N cycles, starting the cycle after the load.
module hazard_stall_ctrl_md_busy_counter #(
    parameter int CNT_W       = 4,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             is_div,
    output logic             busy,
    output logic [CNT_W-1:0] value
);
    logic [CNT_W-1:0] cnt;

    // Reset aborts any countdown; a new start always reloads, even mid-count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy  = (cnt != '0);
    assign value = cnt;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller: Tuse/Tnew register hazards plus the
// mult/div busy interlock. EX_MEM and MEM_WB always advance.
// Optional feature macro: HAZARD_PERF_EN (stall_cycles, md_stall_cycles).
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    hazard_stall_ctrl_if.slave hz
);
    logic             rs_hz;
    logic             rt_hz;
    logic             md_hz;
    logic             md_busy;
    logic [CNT_W-1:0] md_cnt;

    // The EX-stage start is never gated: EX always advances, so the unit starts.
    hazard_stall_ctrl_md_busy_counter #(
        .CNT_W      (CNT_W),
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk   (clk),
        .reset (reset),
        .load  (hz.ex_md_start),
        .is_div(hz.ex_md_is_div),
        .busy  (md_busy),
        .value (md_cnt)
    );

    // Hazard detection: a result arriving later than the consumer needs it.
    always_comb begin
        rs_hz = src_hit(hz.id_rs, hz.id_tuse_rs, hz.ex_dst, hz.ex_tnew)
              | src_hit(hz.id_rs, hz.id_tuse_rs, hz.mem_dst, hz.mem_tnew);
        rt_hz = src_hit(hz.id_rt, hz.id_tuse_rt, hz.ex_dst, hz.ex_tnew)
              | src_hit(hz.id_rt, hz.id_tuse_rt, hz.mem_dst, hz.mem_tnew);
        md_hz = hz.id_is_md & (md_busy | hz.ex_md_start);
    end

    // Pipeline controls; reset forces the pipe open and a bubble into ID_EX.
    always_comb begin
        hz.stall       = 1'b0;
        hz.pc_en       = 1'b1;
        hz.if_id_en    = 1'b1;
        hz.id_ex_flush = 1'b1;
        if (!reset) begin
            hz.stall       = rs_hz | rt_hz | md_hz;
            hz.pc_en       = ~hz.stall;
            hz.if_id_en    = ~hz.stall;
            hz.id_ex_flush = hz.stall;
        end
    end

    assign hz.md_busy = md_busy;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] md_stall_cnt;

    // Free-running stall counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt    <= '0;
            md_stall_cnt <= '0;
        end else begin
            if (hz.stall) stall_cnt <= stall_cnt + 32'd1;
            if (md_hz)    md_stall_cnt <= md_stall_cnt + 32'd1;
        end
    end

    assign hz.stall_cycles    = stall_cnt;
    assign hz.md_stall_cycles = md_stall_cnt;

    logic unused_cnt;
    assign unused_cnt = ^md_cnt;
`else
    logic unused_cnt;
    assign unused_cnt = ^md_cnt;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed pins plus randomized traffic
// against a cycle-indexed behavioural model.
// Optional feature macro: HAZARD_PERF_EN (perf counters also checked).
module tb_hazard_stall_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if hz ();

    hazard_stall_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N),
        .CNT_W      (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz.slave)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    // The unit is busy on cycle c exactly when c < busy_end; a start seen on
    // cycle s makes it busy on cycles s+1 .. s+N.
    longint cyc = 0;
    longint busy_end = 0;
    bit     model_ok = 1'b0;
    longint m_stall_cnt = 0;
    longint m_md_cnt = 0;

    function automatic bit m_busy();
        return cyc < busy_end;
    endfunction

    function automatic bit m_src(input logic [4:0] r, input logic [1:0] tuse);
        bit hit = 0;
        if (r != 0) begin
            if (r == hz.ex_dst && int'(tuse) < int'(hz.ex_tnew)) hit = 1;
            if (r == hz.mem_dst && int'(tuse) < int'(hz.mem_tnew)) hit = 1;
        end
        return hit;
    endfunction

    function automatic bit m_md_hz();
        return hz.id_is_md && (m_busy() || hz.ex_md_start);
    endfunction

    function automatic bit m_stall();
        if (reset) return 0;
        return m_src(hz.id_rs, hz.id_tuse_rs) || m_src(hz.id_rt, hz.id_tuse_rt) || m_md_hz();
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            busy_end    <= 0;
            m_stall_cnt <= 0;
            m_md_cnt    <= 0;
            model_ok    <= 1'b1;
        end else begin
            if (hz.ex_md_start) busy_end <= cyc + 1 + (hz.ex_md_is_div ? DIV_N : MULT_N);
            if (m_stall()) m_stall_cnt <= (m_stall_cnt + 1) % 64'h1_0000_0000;
            if (m_md_hz()) m_md_cnt <= (m_md_cnt + 1) % 64'h1_0000_0000;
        end
        cyc <= cyc + 1;
    end

    // ---------------- scoreboard ----------------
    // exp_q holds hand-computed {stall, pc_en, if_id_en, id_ex_flush, md_busy}
    // for directed cycles, one entry per cycle, consumed in order.
    logic [4:0] exp_q[$];
    logic [4:0] act_v;
    logic [4:0] mdl_v;
    logic [4:0] lit_v;
    bit         s;

    always @(negedge clk) begin
        if (model_ok) begin
            s      = m_stall();
            mdl_v  = {s, reset ? 1'b1 : !s, reset ? 1'b1 : !s, reset ? 1'b1 : s, m_busy()};
            act_v  = {hz.stall, hz.pc_en, hz.if_id_en, hz.id_ex_flush, hz.md_busy};
            checks++;
            if (act_v !== mdl_v) begin
                errors++;
                $display("FAIL model cyc=%0d got=%b want=%b (stall,pc_en,if_id_en,flush,busy)",
                         cyc, act_v, mdl_v);
            end
            if (exp_q.size() != 0) begin
                lit_v = exp_q.pop_front();
                checks++;
                if (act_v !== lit_v) begin
                    errors++;
                    $display("FAIL pin cyc=%0d got=%b want=%b (stall,pc_en,if_id_en,flush,busy)",
                             cyc, act_v, lit_v);
                end
            end
`ifdef HAZARD_PERF_EN
            checks++;
            if (hz.stall_cycles !== 32'(m_stall_cnt) || hz.md_stall_cycles !== 32'(m_md_cnt)) begin
                errors++;
                $display("FAIL perf cyc=%0d got=%0d/%0d want=%0d/%0d", cyc,
                         hz.stall_cycles, hz.md_stall_cycles, m_stall_cnt, m_md_cnt);
            end
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        hz.id_rs = 0; hz.id_rt = 0;
        hz.id_tuse_rs = 2'd3; hz.id_tuse_rt = 2'd3;
        hz.id_is_md = 0;
        hz.ex_dst = 0; hz.ex_tnew = 0;
        hz.mem_dst = 0; hz.mem_tnew = 0;
        hz.ex_md_start = 0; hz.ex_md_is_div = 0;
        reset = 0;
    endtask

    // Hold the current inputs for one cycle, optionally pinning a literal.
    task automatic cycle(input bit pin, input logic [4:0] v);
        if (pin) exp_q.push_back(v);
        @(posedge clk);
        #1;
    endtask

    task automatic random_inputs();
        hz.id_rs        = 5'($urandom_range(0, 3));
        hz.id_rt        = 5'($urandom_range(0, 3));
        hz.id_tuse_rs   = 2'($urandom_range(0, 3));
        hz.id_tuse_rt   = 2'($urandom_range(0, 3));
        hz.id_is_md     = ($urandom_range(0, 2) == 0);
        hz.ex_dst       = 5'($urandom_range(0, 3));
        hz.ex_tnew      = 2'($urandom_range(0, 3));
        hz.mem_dst      = 5'($urandom_range(0, 3));
        hz.mem_tnew     = 2'($urandom_range(0, 3));
        hz.ex_md_start  = ($urandom_range(0, 11) == 0);
        hz.ex_md_is_div = $urandom_range(0, 1) == 1;
        reset           = ($urandom_range(0, 99) == 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        set_idle();
        reset = 1;
        cycle(0, 5'b0);
        cycle(1, 5'b01110);              // in reset, counter already cleared
        reset = 0;
        cycle(1, 5'b01100);              // idle

        // load-use: lw $1 in EX, addu using $1 in ID
        hz.ex_dst = 1; hz.ex_tnew = 2; hz.id_rs = 1; hz.id_tuse_rs = 1;
        cycle(1, 5'b10010);
        hz.ex_dst = 0; hz.ex_tnew = 0; hz.mem_dst = 1; hz.mem_tnew = 1;
        cycle(1, 5'b01100);

        // $0 immunity
        set_idle();
        hz.ex_dst = 0; hz.ex_tnew = 2; hz.id_rs = 0; hz.id_tuse_rs = 0;
        cycle(1, 5'b01100);
        // rt hazard via MEM, and Tuse 3 immunity
        set_idle();
        hz.id_rt = 5; hz.id_tuse_rt = 0; hz.mem_dst = 5; hz.mem_tnew = 1;
        cycle(1, 5'b10010);
        hz.id_tuse_rt = 2'd3; hz.mem_tnew = 2'd3;
        cycle(1, 5'b01100);

        // mult at t, mflo waiting from t+1
        set_idle();
        hz.ex_md_start = 1;
        cycle(1, 5'b01100);
        hz.ex_md_start = 0; hz.id_is_md = 1;
        for (int i = 0; i < MULT_N; i++) cycle(1, 5'b10011);
        cycle(1, 5'b01100);              // mflo issues

        // div with reload at busy cycle 4
        set_idle();
        hz.ex_md_start = 1; hz.ex_md_is_div = 1;
        cycle(1, 5'b01100);
        hz.ex_md_start = 0;
        for (int i = 0; i < 3; i++) cycle(1, 5'b01101);
        hz.ex_md_start = 1;
        cycle(1, 5'b01101);              // busy cycle 4, reload
        hz.ex_md_start = 0;
        for (int i = 0; i < DIV_N; i++) cycle(1, 5'b01101);
        cycle(1, 5'b01100);

        // reset at busy cycle 3 of a div, with register and md hazards pending
        hz.ex_md_start = 1;
        cycle(1, 5'b01100);
        hz.ex_md_start = 0; hz.ex_md_is_div = 0;
        cycle(1, 5'b01101);
        cycle(1, 5'b01101);
        reset = 1; hz.id_is_md = 1; hz.ex_dst = 2; hz.ex_tnew = 2; hz.id_rs = 2; hz.id_tuse_rs = 0;
        cycle(1, 5'b01111);
        reset = 0; hz.ex_dst = 0;
        cycle(1, 5'b01100);

        // simultaneous register and md hazard: one stall
        set_idle();
        hz.ex_md_start = 1; hz.id_is_md = 1;
        hz.ex_dst = 3; hz.ex_tnew = 1; hz.id_rs = 3; hz.id_tuse_rs = 0;
        cycle(1, 5'b10010);
        set_idle();
        for (int i = 0; i < MULT_N; i++) cycle(1, 5'b01101);
        cycle(1, 5'b01100);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            cycle(0, 5'b0);
        end

        set_idle();
        cycle(0, 5'b0);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pin_queue left=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
